instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the multicycle RV32I core; sits directly upstream of register_file.
//  Holds PC, OldPC and the instruction register (IR), and issues word reads to instruction memory.
//  IR drives register_file.instr and is stable between fetches. Controller requests fetches and redirects.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset; must be word aligned
//  NOP_INSTR   32'h0000_0013  IR reset value (addi x0,x0,0)
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  reset         in   1   synchronous, active-high
//  fetch_en      in   1   controller requests the next instruction; sampled only in IDLE
//  redirect      in   1   load PC from redirect_pc (branch/jump target)
//  redirect_pc   in   32  redirect target
//  mem_req       out  1   read request to instruction memory
//  mem_addr      out  32  word address of request (= PC register)
//  mem_ready     in   1   memory accepts request this cycle when mem_req=1
//  mem_rvalid    in   1   read data valid
//  mem_rdata     in   32  read data
//  instr         out  32  IR; feeds register_file.instr
//  pc            out  32  PC of next fetch
//  pc_old        out  32  PC of instruction currently in IR
//  instr_valid   out  1   one-cycle pulse: IR updated this cycle
//  misalign_err  out  1   sticky: redirect_pc[1:0]!=0 seen
// BEHAVIOUR
//  Reset: state=IDLE; pc=pc_old=RESET_PC; instr=NOP_INSTR; instr_valid=0; mem_req=0;
//   misalign_err=0; redir_pend=0. Reset mid-transaction abandons it; later rvalid is ignored.
//  FSM states IDLE, REQ, WAIT:
//   IDLE: mem_req=0. redirect (aligned) -> pc<=redirect_pc. fetch_en & !misalign_err -> REQ.
//    Same-cycle redirect+fetch_en: PC loads redirect_pc; the REQ fetches that target.
//   REQ: mem_req=1, mem_addr=pc (registered, glitch-free). mem_ready -> WAIT; else stay in REQ.
//   WAIT: mem_req=0. On mem_rvalid: instr<=mem_rdata, pc_old<=pc, instr_valid<=1 next cycle,
//    pc<=redir_pend ? pend_pc : pc+4; clear redir_pend; go to IDLE.
//  Latency: fetch_en in IDLE to instr_valid = 3 cycles minimum
//   (REQ with ready=1, WAIT with rvalid=1, pulse in the following cycle).
//  Redirect in REQ/WAIT: pend_pc<=redirect_pc, redir_pend<=1. The in-flight fetch still completes.
//   The last redirect wins.
//  pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
//  Misaligned redirect: misalign_err<=1 (sticky until reset). PC and pend_pc are unchanged.
//   fetch_en is ignored afterwards; an in-flight fetch still completes normally.
//  mem_rvalid outside WAIT is ignored. mem_rdata is sampled only on rvalid in WAIT.
//  instr, pc_old hold between fetches. instr_valid is high exactly 1 cycle per completed fetch.
// STRUCTURE
//  rv_pkg: fetch_state_t enum {IDLE,REQ,WAIT}; NOP_INSTR constant; XLEN=32.
//  Single module: state register, PC/OldPC/IR registers, pending-redirect register.
//  No sub-module; the pc+4 adder is inline.
// TESTING
//  1 reset, fetch_en pulse, mem ready=1, rvalid next cycle with rdata=32'h0020_8133
//    -> instr=32'h0020_8133, pc_old=0, pc=4, instr_valid for 1 cycle, 3 cycles after fetch_en.
//  2 mem_ready low 4 cycles, rvalid delayed 5 cycles
//    -> mem_req/mem_addr stable through REQ; exactly one instr_valid; pc=4.
//  3 redirect=1 with redirect_pc=32'h0000_0100 during WAIT
//    -> fetched instr lands with pc_old=0, then pc=32'h100; next fetch mem_addr=32'h100.
//  4 redirect to 32'hFFFF_FFFC, then fetch
//    -> pc_old=32'hFFFF_FFFC, pc wraps to 0.
//  5 redirect_pc=32'h0000_0102
//    -> misalign_err=1 sticky, pc unchanged, subsequent fetch_en gives no mem_req.
//  6 reset asserted in WAIT, then rvalid arrives
//    -> state IDLE, instr=NOP_INSTR, pc=RESET_PC, no instr_valid.

Source files
------------

// File: rtl/rv_pkg.sv
// ============================================================================
// Package : rv_pkg
// Brief   : Shared types and constants for the multicycle RV32I core.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module  : instr_fetch
// Brief   : Fetch stage: PC / OldPC / IR registers and instruction-memory reads.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_old,
  output logic        instr_valid,
  output logic        misalign_err
);

  import rv_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic            r_mem_req;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_old;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_misalign_err;
  logic            r_redir_pend;
  logic [XLEN-1:0] r_pend_pc;

  logic            w_redir_ok;
  logic            w_redir_bad;
  logic            w_done;
  logic [XLEN-1:0] w_pc_inc;

  assign w_redir_ok  = redirect & (redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = redirect & (redirect_pc[1:0] != 2'b00);
  assign w_done      = (r_state == WAIT) & mem_rvalid;
  assign w_pc_inc    = r_pc + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (fetch_en && !r_misalign_err) w_state_nxt = REQ;
      REQ:     if (mem_ready)                   w_state_nxt = WAIT;
      WAIT:    if (mem_rvalid)                  w_state_nxt = IDLE;
      default:                                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mem_req      <= 1'b0;
      r_pc           <= RESET_PC;
      r_pc_old       <= RESET_PC;
      r_instr        <= NOP_INSTR;
      r_instr_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
      r_redir_pend   <= 1'b0;
      r_pend_pc      <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      // Request is a flop of its own so mem_req never glitches on state decode.
      r_mem_req     <= (w_state_nxt == REQ);
      r_instr_valid <= w_done;
      if (w_redir_bad) r_misalign_err <= 1'b1;

      if (r_state == IDLE) begin
        if (w_redir_ok) r_pc <= redirect_pc;
      end else if (w_done) begin
        r_instr      <= mem_rdata;
        r_pc_old     <= r_pc;
        // A redirect arriving on the completion cycle is the most recent one.
        r_pc         <= w_redir_ok   ? redirect_pc :
                        r_redir_pend ? r_pend_pc   : w_pc_inc;
        r_redir_pend <= 1'b0;
      end else if (w_redir_ok) begin
        r_redir_pend <= 1'b1;
        r_pend_pc    <= redirect_pc;
      end
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_pc;
  assign instr        = r_instr;
  assign pc           = r_pc;
  assign pc_old       = r_pc_old;
  assign instr_valid  = r_instr_valid;
  assign misalign_err = r_misalign_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Scoreboard bench for instr_fetch with a transaction-level PC model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_old;
  logic        instr_valid;
  logic        misalign_err;

  instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr(instr), .pc(pc), .pc_old(pc_old), .instr_valid(instr_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  int n_valid = 0;
  int last_valid_cnt = 0;
  int fe_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_old;
    logic [31:0] pc;
    int          at;
  } exp_t;
  exp_t sb[$];

  // Architectural reference state
  logic [31:0] m_pc, m_pc_old, m_instr, m_pend_pc;
  bit          m_err, m_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid) begin
      n_valid++;
      last_valid_cnt = cyc_cnt;
      if (sb.size() == 0) begin
        chk("unexpected_instr_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc_old", pc_old, e.pc_old);
        chk("sb_pc", pc, e.pc);
        chk("sb_valid_cycle", cyc_cnt, e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(output logic req, output logic [31:0] addr);
    @(negedge clk);
    req  = mem_req;
    addr = mem_addr;
  endtask

  task automatic idle_inputs();
    fetch_en   = 1'b0;
    redirect   = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    int r;
    r = $urandom_range(0, 99);
    if (r < 3)       t = {$urandom} | 32'h1;
    else if (r < 10) t = 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
    else             t = {$urandom} & 32'hFFFF_FFFC;
    return t;
  endfunction

  // Idle redirects move the PC directly; busy ones become pending; last wins.
  task automatic model_redirect(input logic [31:0] t, input bit busy);
    if (t[1:0] != 2'b00) m_err = 1'b1;
    else if (busy) begin
      m_pend    = 1'b1;
      m_pend_pc = t;
    end else m_pc = t;
  endtask

  task automatic maybe_redirect(input int pct, input bit busy);
    if (pct > 0 && $urandom_range(0, 99) < pct) begin
      redirect    = 1'b1;
      redirect_pc = rand_target();
      model_redirect(redirect_pc, busy);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    m_pc     = RST_PC;
    m_pc_old = RST_PC;
    m_instr  = NOP;
    m_err    = 1'b0;
    m_pend   = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    logic r;
    logic [31:0] a;
    obs(r, a);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_pc_old"}, pc_old, m_pc_old);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_misalign"}, {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  task automatic redirect_idle(input logic [31:0] t);
    idle_inputs();
    redirect    = 1'b1;
    redirect_pc = t;
    model_redirect(t, 1'b0);
    tick();
    idle_inputs();
  endtask

  // rdy_wait/rv_delay < 0 mean random; wr_idx selects a WAIT cycle for a forced redirect.
  task automatic fetch(input int rdy_wait, input int rv_delay, input int redir_pct,
                       input logic [31:0] data, input int wr_idx, input logic [31:0] wr_pc);
    logic        req;
    logic [31:0] addr;
    logic [31:0] npc;
    bit          acc;
    bit          err0;
    int          d;
    exp_t        e;
    err0 = m_err;
    idle_inputs();
    fetch_en = 1'b1;
    maybe_redirect(redir_pct, 1'b0);
    fe_cnt = cyc_cnt;
    tick();
    idle_inputs();
    if (err0) begin
      for (int i = 0; i < 4; i++) begin
        fetch_en = 1'b1;
        obs(req, addr);
        chk("no_req_after_err", {31'd0, req}, 32'd0);
        tick();
      end
      fetch_en = 1'b0;
      return;
    end
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      idle_inputs();
      mem_ready = (rdy_wait < 0) ? ($urandom_range(0, 99) < 60) : (i >= rdy_wait);
      maybe_redirect(redir_pct, 1'b1);
      obs(req, addr);
      if (req) chk("req_mem_addr", addr, m_pc);
      tick();
      if (req && mem_ready) acc = 1'b1;
    end
    if (!acc) begin
      chk("req_timeout", 32'd1, 32'd0);
      do_reset();
      return;
    end
    d = (rv_delay < 0) ? $urandom_range(0, 4) : rv_delay;
    for (int i = 0; i < d; i++) begin
      idle_inputs();
      if (i == wr_idx) begin
        redirect    = 1'b1;
        redirect_pc = wr_pc;
        model_redirect(wr_pc, 1'b1);
      end else maybe_redirect(redir_pct, 1'b1);
      obs(req, addr);
      chk("wait_no_req", {31'd0, req}, 32'd0);
      tick();
    end
    idle_inputs();
    maybe_redirect(redir_pct, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    npc = m_pend ? m_pend_pc : m_pc + 32'd4;
    e.instr  = data;
    e.pc_old = m_pc;
    e.pc     = npc;
    e.at     = cyc_cnt + 1;
    sb.push_back(e);
    m_pc_old = m_pc;
    m_pc     = npc;
    m_instr  = data;
    m_pend   = 1'b0;
    tick();
    idle_inputs();
  endtask

  initial begin
    logic        req;
    logic [31:0] addr;
    int          nv;

    // Reset state
    do_reset();
    obs(req, addr);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_old", pc_old, RST_PC);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    tick();

    // 1: minimum latency fetch
    nv = n_valid;
    fetch(0, 0, 0, 32'h0020_8133, -1, 32'd0);
    tick();
    chk("t1_latency", 32'(last_valid_cnt - fe_cnt), 32'd3);
    chk("t1_one_pulse", 32'(n_valid - nv), 32'd1);
    chk("t1_pc", pc, 32'd4);
    chk("t1_valid_low", {31'd0, instr_valid}, 32'd0);

    // 2: slow memory
    do_reset();
    nv = n_valid;
    fetch(4, 5, 0, $urandom, -1, 32'd0);
    tick();
    chk("t2_one_pulse", 32'(n_valid - nv), 32'd1);
    chk("t2_pc", pc, 32'd4);

    // 3: redirect during WAIT
    do_reset();
    fetch(0, 2, 0, $urandom, 1, 32'h0000_0100);
    check_arch("t3");
    chk("t3_pc_target", pc, 32'h0000_0100);
    fetch(0, 0, 0, $urandom, -1, 32'd0);
    check_arch("t3b");

    // 4: wrap past the top of the address space
    redirect_idle(32'hFFFF_FFFC);
    fetch(0, 1, 0, $urandom, -1, 32'd0);
    check_arch("t4");
    chk("t4_pc_old", pc_old, 32'hFFFF_FFFC);
    chk("t4_pc_wrap", pc, 32'd0);

    // 5: misaligned redirect
    redirect_idle(32'h0000_0102);
    check_arch("t5");
    chk("t5_err", {31'd0, misalign_err}, 32'd1);
    fetch(0, 0, 0, $urandom, -1, 32'd0);
    check_arch("t5b");

    // 6: reset while WAIT, stray rvalid afterwards
    do_reset();
    nv = n_valid;
    idle_inputs();
    fetch_en = 1'b1;
    tick();
    idle_inputs();
    mem_ready = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    tick();
    tick();
    obs(req, addr);
    chk("t6_instr", instr, NOP);
    chk("t6_pc", pc, RST_PC);
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_no_valid", 32'(n_valid - nv), 32'd0);
    tick();
    m_pc = RST_PC; m_pc_old = RST_PC; m_instr = NOP; m_err = 1'b0; m_pend = 1'b0;
    fetch(0, 0, 0, $urandom, -1, 32'd0);
    check_arch("t6b");

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        idle_inputs();
        maybe_redirect(25, 1'b0);
        mem_rvalid = ($urandom_range(0, 3) == 0);
        tick();
      end
      fetch(-1, -1, 20, $urandom, -1, 32'd0);
      check_arch("rnd");
      if (m_err) begin
        fetch(-1, -1, 0, $urandom, -1, 32'd0);
        do_reset();
      end
    end

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
